// File: rtl/mastermind_round_ctrl.sv
// Round controller for one Mastermind game: secret request, guess intake, checker latency
// wait, score latching, attempt counting and win/loss status.
module mastermind_round_ctrl #(
    parameter int unsigned MAX_ATTEMPTS = 10,
    parameter int unsigned ATT_W        = 4,
    parameter int unsigned CHECK_LAT    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             guess_submit,
    input  logic [3:0]       correct_place_count,
    input  logic [3:0]       wrong_place_count,
    output logic             secret_load,
    output logic             guess_ready,
    output logic             result_valid,
    output logic [3:0]       last_correct,
    output logic [3:0]       last_wrong,
    output logic [ATT_W-1:0] attempts,
    output logic             game_won,
    output logic             game_lost,
    output logic [2:0]       state_code
);

    localparam int unsigned CNT_W = $clog2(CHECK_LAT + 1);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPlay = 3'd1,
        StWait = 3'd2,
        StEval = 3'd3,
        StWin  = 3'd4,
        StLose = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         corr_q, corr_d;
    logic [3:0]         wrong_q, wrong_d;
    logic [ATT_W-1:0]   att_q, att_d;
    logic               load_q, load_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        corr_d  = corr_q;
        wrong_d = wrong_q;
        att_d   = att_q;
        load_d  = 1'b0;

        if (abort) begin
            // Abort beats every other input; clearing in IDLE is harmless since all are 0.
            state_d = StIdle;
            cnt_d   = '0;
            corr_d  = '0;
            wrong_d = '0;
            att_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StWin, StLose: begin
                    if (start) begin
                        state_d = StPlay;
                        load_d  = 1'b1;
                        corr_d  = '0;
                        wrong_d = '0;
                        att_d   = '0;
                    end
                end
                StPlay: begin
                    if (guess_submit) begin
                        state_d = StWait;
                        cnt_d   = CNT_W'(CHECK_LAT);
                    end
                end
                StWait: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StEval;
                        cnt_d   = '0;
                        corr_d  = correct_place_count;
                        wrong_d = wrong_place_count;
                        att_d   = att_q + ATT_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StEval: begin
                    if (corr_q == 4'd4) begin
                        state_d = StWin;
                    end else if (att_q == ATT_W'(MAX_ATTEMPTS)) begin
                        state_d = StLose;
                    end else begin
                        state_d = StPlay;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            corr_q  <= '0;
            wrong_q <= '0;
            att_q   <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            corr_q  <= corr_d;
            wrong_q <= wrong_d;
            att_q   <= att_d;
            load_q  <= load_d;
        end
    end

    assign secret_load  = load_q;
    assign guess_ready  = (state_q == StPlay);
    assign result_valid = (state_q == StEval);
    assign game_won     = (state_q == StWin);
    assign game_lost    = (state_q == StLose);
    assign last_correct = corr_q;
    assign last_wrong   = wrong_q;
    assign attempts     = att_q;
    assign state_code   = state_q;

endmodule

// File: tb/tb_mastermind_round_ctrl.sv
// Table-driven bench for mastermind_round_ctrl: a CHECK_LAT=1 instance runs the vector
// table, a CHECK_LAT=3 instance checks the longer checker latency.
module tb_mastermind_round_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       guess_submit = 1'b0;
    logic [3:0] correct_place_count = '0;
    logic [3:0] wrong_place_count = '0;

    logic       a_sl, a_gr, a_rv, a_won, a_lost;
    logic [3:0] a_lc, a_lw, a_att;
    logic [2:0] a_st;
    logic       b_sl, b_gr, b_rv, b_won, b_lost;
    logic [3:0] b_lc, b_lw, b_att;
    logic [2:0] b_st;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mastermind_round_ctrl #(.MAX_ATTEMPTS(10), .ATT_W(4), .CHECK_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .guess_submit(guess_submit),
        .correct_place_count(correct_place_count), .wrong_place_count(wrong_place_count),
        .secret_load(a_sl), .guess_ready(a_gr), .result_valid(a_rv), .last_correct(a_lc),
        .last_wrong(a_lw), .attempts(a_att), .game_won(a_won), .game_lost(a_lost),
        .state_code(a_st)
    );

    mastermind_round_ctrl #(.MAX_ATTEMPTS(10), .ATT_W(4), .CHECK_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .guess_submit(guess_submit),
        .correct_place_count(correct_place_count), .wrong_place_count(wrong_place_count),
        .secret_load(b_sl), .guess_ready(b_gr), .result_valid(b_rv), .last_correct(b_lc),
        .last_wrong(b_lw), .attempts(b_att), .game_won(b_won), .game_lost(b_lost),
        .state_code(b_st)
    );

    // Packed outputs: {secret_load, guess_ready, result_valid, lc, lw, attempts, won, lost, state}
    typedef struct {
        string       name;
        logic        st;
        logic        ab;
        logic        sb;
        logic [3:0]  cc;
        logic [3:0]  wc;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, bit s, bit a, bit g, int cc, int wc,
                                bit sl, int lc, int lw, int att, int st);
        vec_t v;
        v.name = n;
        v.st   = s;
        v.ab   = a;
        v.sb   = g;
        v.cc   = 4'(cc);
        v.wc   = 4'(wc);
        v.exp  = {sl, st == 1, st == 3, 4'(lc), 4'(lw), 4'(att), st == 4, st == 5, 3'(st)};
        return v;
    endfunction

    function automatic void add(string n, bit s, bit a, bit g, int cc, int wc,
                                bit sl, int lc, int lw, int att, int st);
        vecs.push_back(mk(n, s, a, g, cc, wc, sl, lc, lw, att, st));
    endfunction

    function automatic logic [19:0] out_a();
        return {a_sl, a_gr, a_rv, a_lc, a_lw, a_att, a_won, a_lost, a_st};
    endfunction

    function automatic logic [19:0] out_b();
        return {b_sl, b_gr, b_rv, b_lc, b_lw, b_att, b_won, b_lost, b_st};
    endfunction

    task automatic check(string n, logic [19:0] got, logic [19:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h", n, got, exp);
        end
    endtask

    // Drive inputs at negedge, sample one unit after the following posedge.
    task automatic apply(vec_t v, bit use_b);
        @(negedge clk);
        start               = v.st;
        abort               = v.ab;
        guess_submit        = v.sb;
        correct_place_count = v.cc;
        wrong_place_count   = v.wc;
        @(posedge clk);
        #1;
        check(v.name, use_b ? out_b() : out_a(), v.exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0; abort = 1'b0; guess_submit = 1'b0;
        correct_place_count = '0; wrong_place_count = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Opening game: start, two scored guesses, win on third.
        add("idle",          0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add("start",         1, 0, 0, 0, 0,  1, 0, 0, 0, 1);
        add("play",          0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        add("sub1",          0, 0, 1, 1, 2,  0, 0, 0, 0, 2);
        add("eval1",         0, 0, 0, 1, 2,  0, 1, 2, 1, 3);
        add("back_play1",    0, 0, 0, 0, 0,  0, 1, 2, 1, 1);
        add("start_in_play", 1, 0, 0, 0, 0,  0, 1, 2, 1, 1);
        add("sub2",          0, 0, 1, 0, 12, 0, 1, 2, 1, 2);
        add("eval2_w12",     0, 0, 0, 0, 12, 0, 0, 12, 2, 3);
        add("back_play2",    0, 0, 0, 0, 0,  0, 0, 12, 2, 1);
        add("sub3",          0, 0, 1, 4, 0,  0, 0, 12, 2, 2);
        add("eval3",         0, 0, 0, 4, 0,  0, 4, 0, 3, 3);
        add("win",           0, 0, 0, 0, 0,  0, 4, 0, 3, 4);
        add("sub_in_win",    0, 0, 1, 1, 1,  0, 4, 0, 3, 4);
        add("win_hold",      0, 0, 0, 0, 0,  0, 4, 0, 3, 4);
        add("restart_win",   1, 0, 0, 0, 0,  1, 0, 0, 0, 1);
        // Ten misses -> LOSE.
        for (int i = 1; i <= 10; i++) begin
            add($sformatf("loss_sub%0d", i),  0, 0, 1, 0, 0, 0, 0, 0, i - 1, 2);
            add($sformatf("loss_eval%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, i, 3);
            add($sformatf("loss_next%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, i, (i < 10) ? 1 : 5);
        end
        add("sub_in_lose",       0, 0, 1, 3, 3, 0, 0, 0, 10, 5);
        add("start_sub_in_lose", 1, 0, 1, 0, 0, 1, 0, 0, 0, 1);
        // Nine misses then a win on the final attempt: win beats loss.
        for (int i = 1; i <= 10; i++) begin
            add($sformatf("lastwin_sub%0d", i), 0, 0, 1, (i == 10) ? 4 : 0, 0,
                0, 0, 0, i - 1, 2);
            add($sformatf("lastwin_eval%0d", i), 0, 0, 0, (i == 10) ? 4 : 0, 0,
                0, (i == 10) ? 4 : 0, 0, i, 3);
            add($sformatf("lastwin_next%0d", i), 0, 0, 0, 0, 0,
                0, (i == 10) ? 4 : 0, 0, i, (i < 10) ? 1 : 4);
        end
        add("abort_in_win",      0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("start_sub_in_idle", 1, 0, 1, 5, 5, 1, 0, 0, 0, 1);
        add("sub_then_abort",    0, 0, 1, 2, 1, 0, 0, 0, 0, 2);
        add("abort_in_wait",     0, 1, 0, 2, 1, 0, 0, 0, 0, 0);
        add("after_abort",       0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        add("start_again",       1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        add("abort_start_play",  1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add("abort_start_idle",  1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        #2;
        check("in_reset", out_a(), 20'h0);
        check("in_reset_b", out_b(), 20'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i], 1'b0);

        // Asynchronous reset in the middle of WAIT.
        apply(mk("pre_rst_start", 1, 0, 0, 0, 0, 1, 0, 0, 0, 1), 1'b0);
        apply(mk("pre_rst_eval_play", 0, 0, 1, 3, 2, 0, 0, 0, 0, 2), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_midwait", out_a(), 20'h0);
        @(negedge clk);
        reset = 1'b0;
        apply(mk("post_reset_idle", 0, 0, 0, 3, 2, 0, 0, 0, 0, 0), 1'b0);

        // CHECK_LAT=3: counts latched on the third edge after the submit edge.
        do_reset();
        apply(mk("l3_start",  1, 0, 0, 0, 0, 1, 0, 0, 0, 1), 1'b1);
        apply(mk("l3_sub",    0, 0, 1, 3, 1, 0, 0, 0, 0, 2), 1'b1);
        apply(mk("l3_wait1",  0, 0, 0, 3, 1, 0, 0, 0, 0, 2), 1'b1);
        apply(mk("l3_wait2",  0, 0, 0, 3, 1, 0, 0, 0, 0, 2), 1'b1);
        apply(mk("l3_latch",  0, 0, 0, 3, 1, 0, 3, 1, 1, 3), 1'b1);
        apply(mk("l3_play",   0, 0, 0, 0, 0, 0, 3, 1, 1, 1), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
